spi_ram_cmd_engine: RTL and testbench

//  Command/data stage downstream of the SPI slave. Decodes each 10-bit frame
//  (din[9:8] opcode, din[7:0] payload) into write-address, write-data,

---
 rtl/spi_ram_cmd_if.sv | 26 ++
 rtl/spi_ram_cmd_engine.sv | 124 ++++++++++++
 tb/tb_spi_ram_cmd_engine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_cmd_if.sv
// Frame/response bundle between the SPI slave and the RAM command engine.
interface spi_ram_cmd_if;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;
   logic       cmd_err;

   // SPI slave side: supplies frames, consumes read data
   modport master (
      output din,
      output rx_valid,
      input  dout,
      input  tx_valid,
      input  cmd_err
   );

   // Command engine side
   modport slave (
      input  din,
      input  rx_valid,
      output dout,
      output tx_valid,
      output cmd_err
   );
endinterface

// File: rtl/spi_ram_cmd_engine.sv
// Decodes 10-bit SPI frames into address/data operations on a small single-port
// RAM; read data and error pulses go back to the SPI slave one cycle after accept.
module spi_ram_cmd_engine #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned ADDR_SIZE = 8,
   parameter bit          AUTO_INC  = 1'b0
) (
   input logic          clk,
   input logic          rst,
   spi_ram_cmd_if.slave bus_io
);

   // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable in range checks
   localparam int unsigned          CmpW   = ADDR_SIZE + 1;
   localparam logic [CmpW-1:0]      DepthC = CmpW'(MEM_DEPTH);
   localparam logic [CmpW-1:0]      LastC  = CmpW'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {
      OpWrAddr = 2'b00,
      OpWrData = 2'b01,
      OpRdAddr = 2'b10,
      OpRdData = 2'b11
   } op_e;

   typedef enum logic {
      StNoAddr = 1'b0,
      StAddrOk = 1'b1
   } addr_st_e;

   logic [7:0]           mem_q [MEM_DEPTH];

   logic                 rx_q;
   logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
   addr_st_e             wr_st_q, rd_st_q;
   logic [7:0]           dout_q;
   logic                 tx_valid_q, cmd_err_q;

   logic                 accept;
   op_e                  op;
   logic [ADDR_SIZE-1:0] frame_addr;
   logic                 wr_in_range, rd_in_range;
   logic                 wr_ok;
   logic [ADDR_SIZE-1:0] wr_addr_inc, rd_addr_inc;
   logic                 mem_we;

   // Frame decode, range checks and wrapped address increments
   always_comb begin
      accept      = bus_io.rx_valid & ~rx_q;
      op          = op_e'(bus_io.din[9:8]);
      frame_addr  = bus_io.din[ADDR_SIZE-1:0];
      wr_in_range = ({1'b0, wr_addr_q} < DepthC);
      rd_in_range = ({1'b0, rd_addr_q} < DepthC);
      wr_ok       = (wr_st_q == StAddrOk) & wr_in_range;
      wr_addr_inc = ({1'b0, wr_addr_q} == LastC) ? '0 : wr_addr_q + 1'b1;
      rd_addr_inc = ({1'b0, rd_addr_q} == LastC) ? '0 : rd_addr_q + 1'b1;
      mem_we      = accept & (op == OpWrData) & wr_ok;
   end

   // Memory write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_addr_q] <= bus_io.din[7:0];
      end
   end

   // Command FSM: per-direction address state plus registered response pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q       <= 1'b0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wr_st_q    <= StNoAddr;
         rd_st_q    <= StNoAddr;
         dout_q     <= 8'h00;
         tx_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         rx_q       <= bus_io.rx_valid;
         tx_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
         if (accept) begin
            unique case (op)
               OpWrAddr: begin
                  wr_addr_q <= frame_addr;
                  wr_st_q   <= StAddrOk;
               end
               OpWrData: begin
                  if (wr_ok) begin
                     if (AUTO_INC) wr_addr_q <= wr_addr_inc;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
               OpRdAddr: begin
                  rd_addr_q <= frame_addr;
                  rd_st_q   <= StAddrOk;
               end
               OpRdData: begin
                  if (rd_st_q == StAddrOk) begin
                     tx_valid_q <= 1'b1;
                     if (rd_in_range) begin
                        dout_q <= mem_q[rd_addr_q];
                     end else begin
                        dout_q    <= 8'h00;
                        cmd_err_q <= 1'b1;
                     end
                     // Without auto-increment each read consumes its address
                     if (AUTO_INC) rd_addr_q <= rd_addr_inc;
                     else          rd_st_q   <= StNoAddr;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus_io.dout     = dout_q;
   assign bus_io.tx_valid = tx_valid_q;
   assign bus_io.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_cmd_engine.sv
// Scoreboard bench: three engine instances (plain, auto-increment, short memory)
// share one frame bus; each command pushes its expected response, which is
// popped and compared in the cycle after the bench's own view of the accept edge.
module tb_spi_ram_cmd_engine;

   typedef struct packed {
      logic [1:0] k;
      logic       tv;
      logic       err;
      logic [7:0] dout;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] din = '0;
   logic [2:0] rxv = '0;
   logic [2:0] rxv_prev, acc_q;
   logic [2:0] tv_w, err_w;
   logic [7:0] dout_w [3];
   exp_t       sb [$];
   int         n_tests = 0;
   int         n_fail  = 0;

   spi_ram_cmd_if if0 ();
   spi_ram_cmd_if if1 ();
   spi_ram_cmd_if if2 ();

   assign if0.din = din;  assign if0.rx_valid = rxv[0];
   assign if1.din = din;  assign if1.rx_valid = rxv[1];
   assign if2.din = din;  assign if2.rx_valid = rxv[2];

   assign tv_w  = {if2.tx_valid, if1.tx_valid, if0.tx_valid};
   assign err_w = {if2.cmd_err, if1.cmd_err, if0.cmd_err};
   assign dout_w[0] = if0.dout;
   assign dout_w[1] = if1.dout;
   assign dout_w[2] = if2.dout;

   spi_ram_cmd_engine #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if0)
   );
   spi_ram_cmd_engine #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if1)
   );
   spi_ram_cmd_engine #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u_dut2 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if2)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bench-side rising-edge detect: acc_q is high in the cycle where a response is due
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rxv_prev <= '0;
         acc_q    <= '0;
      end else begin
         acc_q    <= rxv & ~rxv_prev;
         rxv_prev <= rxv;
      end
   end

   // Pop and compare on the falling edge; any pulse without an accept is spurious
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (acc_q[k]) begin
            if (sb.size() == 0) begin
               check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("sb_dut", 32'(k), 32'(e.k));
               check_eq($sformatf("tx_valid[%0d]", k), 32'(tv_w[k]), 32'(e.tv));
               check_eq($sformatf("cmd_err[%0d]", k), 32'(err_w[k]), 32'(e.err));
               check_eq($sformatf("dout[%0d]", k), 32'(dout_w[k]), 32'(e.dout));
            end
         end else if (tv_w[k] || err_w[k]) begin
            check_eq($sformatf("spurious[%0d]", k), 32'({tv_w[k], err_w[k]}), 32'd0);
         end
      end
   end

   // Drive one frame to instance k for `hold` cycles and queue its expected response
   task automatic send(input int k, input logic [9:0] f, input int hold,
                       input logic tv, input logic err, input logic [7:0] dexp);
      exp_t e;
      e.k = 2'(k); e.tv = tv; e.err = err; e.dout = dexp;
      sb.push_back(e);
      @(negedge clk);
      din    = f;
      rxv[k] = 1'b1;
      repeat (hold) @(negedge clk);
      rxv[k] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("rst_tv[%0d]", k), 32'(tv_w[k]), 32'd0);
         check_eq($sformatf("rst_err[%0d]", k), 32'(err_w[k]), 32'd0);
         check_eq($sformatf("rst_dout[%0d]", k), 32'(dout_w[k]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Instance 0: no read address yet, then basic write/read, consumed address
      send(0, 10'h300, 1, 1'b0, 1'b1, 8'h00);
      send(0, 10'h012, 1, 1'b0, 1'b0, 8'h00);
      send(0, 10'h1A5, 1, 1'b0, 1'b0, 8'h00);
      send(0, 10'h212, 1, 1'b0, 1'b0, 8'h00);
      send(0, 10'h300, 1, 1'b1, 1'b0, 8'hA5);
      send(0, 10'h300, 1, 1'b0, 1'b1, 8'hA5);
      // Held rx_valid on a read yields one response only
      send(0, 10'h212, 1, 1'b0, 1'b0, 8'hA5);
      send(0, 10'h3FF, 4, 1'b1, 1'b0, 8'hA5);
      // Without auto-increment consecutive writes overwrite one location
      send(0, 10'h034, 1, 1'b0, 1'b0, 8'hA5);
      send(0, 10'h15A, 1, 1'b0, 1'b0, 8'hA5);
      send(0, 10'h1C3, 1, 1'b0, 1'b0, 8'hA5);
      send(0, 10'h234, 1, 1'b0, 1'b0, 8'hA5);
      send(0, 10'h300, 1, 1'b1, 1'b0, 8'hC3);

      // Instance 1 (auto-increment): write before address, held write, wrap at FF
      send(1, 10'h177, 1, 1'b0, 1'b1, 8'h00);
      send(1, 10'h010, 1, 1'b0, 1'b0, 8'h00);
      send(1, 10'h13C, 5, 1'b0, 1'b0, 8'h00);
      send(1, 10'h14D, 1, 1'b0, 1'b0, 8'h00);
      send(1, 10'h210, 1, 1'b0, 1'b0, 8'h00);
      send(1, 10'h300, 1, 1'b1, 1'b0, 8'h3C);
      send(1, 10'h300, 1, 1'b1, 1'b0, 8'h4D);
      send(1, 10'h0FF, 1, 1'b0, 1'b0, 8'h4D);
      send(1, 10'h111, 1, 1'b0, 1'b0, 8'h4D);
      send(1, 10'h122, 1, 1'b0, 1'b0, 8'h4D);
      send(1, 10'h2FF, 1, 1'b0, 1'b0, 8'h4D);
      send(1, 10'h300, 1, 1'b1, 1'b0, 8'h11);
      send(1, 10'h300, 1, 1'b1, 1'b0, 8'h22);

      // Instance 2 (depth 200): last valid word, then first out-of-range address
      send(2, 10'h0C7, 1, 1'b0, 1'b0, 8'h00);
      send(2, 10'h199, 1, 1'b0, 1'b0, 8'h00);
      send(2, 10'h2C7, 1, 1'b0, 1'b0, 8'h00);
      send(2, 10'h300, 1, 1'b1, 1'b0, 8'h99);
      send(2, 10'h0C8, 1, 1'b0, 1'b0, 8'h99);
      send(2, 10'h155, 1, 1'b0, 1'b1, 8'h99);
      send(2, 10'h2C8, 1, 1'b0, 1'b0, 8'h99);
      send(2, 10'h300, 1, 1'b1, 1'b1, 8'h00);

      // Reset in the response cycle of a read: outputs drop before the edge
      send(0, 10'h212, 1, 1'b0, 1'b0, 8'hC3);
      @(negedge clk);
      din    = 10'h300;
      rxv[0] = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_tv", 32'(tv_w[0]), 32'd0);
      check_eq("midrst_err", 32'(err_w[0]), 32'd0);
      check_eq("midrst_dout", 32'(dout_w[0]), 32'd0);
      @(negedge clk);
      rxv[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      // Read flag was cleared, memory was not
      send(0, 10'h300, 1, 1'b0, 1'b1, 8'h00);
      send(0, 10'h212, 1, 1'b0, 1'b0, 8'h00);
      send(0, 10'h300, 1, 1'b1, 1'b0, 8'hA5);

      repeat (3) @(negedge clk);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
